// File: rtl/pipemdu_if.sv
// pipemdu_if: groups the EXE-stage controls, operands and results of the
// multiply unit.
//   emult/emfhi/emflo : instruction decode flags for the instruction in EXE
//   ea/eb             : forwarded rs/rt operands (multiplicand/multiplier)
//   hi/lo             : architectural HI/LO registers
//   mdout             : emfhi ? hi : lo, for the EXE result mux
//   busy/stall        : unit occupied / front-end freeze request
// The master modport belongs to the pipeline; the slave modport belongs to the unit.
interface pipemdu_if #(
  parameter int WIDTH = 32
);
  logic             emult;
  logic             emfhi;
  logic             emflo;
  logic [WIDTH-1:0] ea;
  logic [WIDTH-1:0] eb;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic [WIDTH-1:0] mdout;
  logic             busy;
  logic             stall;

  modport master (
    output emult, emfhi, emflo, ea, eb,
    input  hi, lo, mdout, busy, stall
  );

  modport slave (
    input  emult, emfhi, emflo, ea, eb,
    output hi, lo, mdout, busy, stall
  );
endinterface

// File: rtl/pipemdu.sv
// pipemdu: EXE-stage iterative shift-add multiplier with HI/LO registers.
// A mult seen in EXE while idle loads the operands (magnitudes when SIGNED)
// and runs WIDTH add/shift steps, then one fix-up cycle applies the sign and
// writes HI/LO. While the unit is busy, any later mult/mfhi/mflo in EXE
// raises stall and waits for the first idle cycle.
// Ports:
//   clk : pipeline clock, rising edge
//   rst : synchronous active-high reset
//   bus : pipemdu_if slave (controls, operands, hi/lo/mdout, busy/stall)
module pipemdu #(
  parameter int WIDTH  = 32,
  parameter bit SIGNED = 1'b1
) (
  input logic      clk,
  input logic      rst,
  pipemdu_if.slave bus
);

  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;

  // Absolute value; the most negative input maps to its correct unsigned magnitude.
  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] x);
    if (x[WIDTH-1]) begin
      mag = (~x) + WIDTH'(1);
    end else begin
      mag = x;
    end
  endfunction

  logic [1:0]       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH:0]   acc_q, acc_d;   // one extra bit keeps the add carry
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] mplr_q, mplr_d;
  logic             neg_q, neg_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;

  logic [WIDTH:0]     sum_s;
  logic [2*WIDTH-1:0] prod_s;
  logic [2*WIDTH-1:0] res_s;
  logic               busy_s;

  // Conditional add of the multiplicand for the current multiplier bit.
  assign sum_s  = mplr_q[0] ? (acc_q + {1'b0, mcand_q}) : acc_q;
  // After WIDTH steps the high half has shifted fully into acc and the low half into mplr.
  assign prod_s = {acc_q[WIDTH-1:0], mplr_q};
  assign res_s  = neg_q ? ((~prod_s) + (2*WIDTH)'(1)) : prod_s;

  assign busy_s    = (state_q != S_IDLE);
  assign bus.busy  = busy_s;
  assign bus.stall = busy_s & (bus.emult | bus.emfhi | bus.emflo);
  assign bus.hi    = hi_q;
  assign bus.lo    = lo_q;
  assign bus.mdout = bus.emfhi ? hi_q : lo_q;

  // Next-state logic for the IDLE/RUN/FIX sequence and the datapath registers.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    mcand_d = mcand_q;
    mplr_d  = mplr_q;
    neg_d   = neg_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    case (state_q)
      S_IDLE: begin
        if (bus.emult) begin
          if (SIGNED) begin
            mcand_d = mag(bus.ea);
            mplr_d  = mag(bus.eb);
            neg_d   = bus.ea[WIDTH-1] ^ bus.eb[WIDTH-1];
          end else begin
            mcand_d = bus.ea;
            mplr_d  = bus.eb;
            neg_d   = 1'b0;
          end
          acc_d   = {(WIDTH+1){1'b0}};
          cnt_d   = CW'(WIDTH);
          state_d = S_RUN;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        // {acc,mplr} = {sum,mplr} >> 1
        acc_d  = {1'b0, sum_s[WIDTH:1]};
        mplr_d = {sum_s[0], mplr_q[WIDTH-1:1]};
        cnt_d  = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d = S_FIX;
        end else begin
          state_d = S_RUN;
        end
      end
      S_FIX: begin
        hi_d    = res_s[2*WIDTH-1:WIDTH];
        lo_d    = res_s[WIDTH-1:0];
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= {CW{1'b0}};
      acc_q   <= {(WIDTH+1){1'b0}};
      mcand_q <= {WIDTH{1'b0}};
      mplr_q  <= {WIDTH{1'b0}};
      neg_q   <= 1'b0;
      hi_q    <= {WIDTH{1'b0}};
      lo_q    <= {WIDTH{1'b0}};
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      mcand_q <= mcand_d;
      mplr_q  <= mplr_d;
      neg_q   <= neg_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

endmodule

// File: tb/tb_pipemdu.sv
// tb_pipemdu: drives a signed and an unsigned pipemdu with the same
// instruction stream and compares HI/LO, mdout, busy and stall timing
// against 64-bit arithmetic products and cycle counts.
module tb_pipemdu;

  logic        clk = 1'b0;
  logic        rst;
  logic        emult, emfhi, emflo;
  logic [31:0] ea, eb;

  int total = 0;
  int bad   = 0;

  pipemdu_if #(.WIDTH(32)) if_s ();
  pipemdu_if #(.WIDTH(32)) if_u ();

  assign if_s.emult = emult;
  assign if_s.emfhi = emfhi;
  assign if_s.emflo = emflo;
  assign if_s.ea    = ea;
  assign if_s.eb    = eb;
  assign if_u.emult = emult;
  assign if_u.emfhi = emfhi;
  assign if_u.emflo = emflo;
  assign if_u.ea    = ea;
  assign if_u.eb    = eb;

  pipemdu #(.WIDTH(32), .SIGNED(1'b1)) dut_s (.clk(clk), .rst(rst), .bus(if_s));
  pipemdu #(.WIDTH(32), .SIGNED(1'b0)) dut_u (.clk(clk), .rst(rst), .bus(if_u));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference product from plain 64-bit arithmetic.
  function automatic logic [63:0] ref_prod(input logic [31:0] a, input logic [31:0] b, input bit sgn);
    longint      sa, sb;
    logic [63:0] ua, ub;
    if (sgn) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      return 64'(sa * sb);
    end else begin
      ua = {32'h0, a};
      ub = {32'h0, b};
      return ua * ub;
    end
  endfunction

  // Issue one mult, count busy cycles and check the results of both units.
  task automatic do_mult(input logic [31:0] a, input logic [31:0] b);
    int          nbusy_s = 0;
    int          nbusy_u = 0;
    bit          done = 0;
    logic [63:0] ps, pu;
    ps = ref_prod(a, b, 1'b1);
    pu = ref_prod(a, b, 1'b0);
    @(negedge clk);
    emult = 1'b1; ea = a; eb = b;
    @(posedge clk);
    @(negedge clk);
    emult = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (if_s.busy) nbusy_s++;
      if (if_u.busy) nbusy_u++;
      if (!if_s.busy && !if_u.busy) begin
        done = 1;
        break;
      end
      @(negedge clk);
    end
    chk("timeout", {63'd0, done}, 64'd1);
    chk("busy_cycles_s", 64'(nbusy_s), 64'd33);
    chk("busy_cycles_u", 64'(nbusy_u), 64'd33);
    chk("hilo_s", {if_s.hi, if_s.lo}, ps);
    chk("hilo_u", {if_u.hi, if_u.lo}, pu);
    chk("mdout_lo_s", {32'h0, if_s.mdout}, {32'h0, ps[31:0]});
    emfhi = 1'b1;
    #1;
    chk("mdout_hi_s", {32'h0, if_s.mdout}, {32'h0, ps[63:32]});
    chk("mdout_hi_u", {32'h0, if_u.mdout}, {32'h0, pu[63:32]});
    emfhi = 1'b0;
  endtask

  // mult followed immediately by mflo: mflo waits for the result.
  task automatic mflo_hazard();
    int nstall = 0;
    bit done = 0;
    @(negedge clk);
    emult = 1'b1; ea = 32'd3; eb = 32'd4;
    @(posedge clk);
    @(negedge clk);
    emult = 1'b0; emflo = 1'b1;
    for (int i = 0; i < 200; i++) begin
      if (!if_s.stall) begin
        done = 1;
        break;
      end
      nstall++;
      @(negedge clk);
    end
    chk("mflo_timeout", {63'd0, done}, 64'd1);
    chk("mflo_stall_cycles", 64'(nstall), 64'd33);
    chk("mflo_mdout_s", {32'h0, if_s.mdout}, 64'h0000000C);
    chk("mflo_mdout_u", {32'h0, if_u.mdout}, 64'h0000000C);
    @(negedge clk);
    emflo = 1'b0;
  endtask

  // Back-to-back mults: the second is held in EXE until the unit is idle.
  task automatic b2b();
    int nbusy = 0;
    bit launched = 0;
    bit done = 0;
    @(negedge clk);
    emult = 1'b1; ea = 32'd2; eb = 32'd3;
    @(posedge clk);
    @(negedge clk);
    ea = 32'd5; eb = 32'd5;
    for (int i = 0; i < 300; i++) begin
      if (if_s.busy) nbusy++;
      if (!launched && !if_s.stall) begin
        launched = 1;
      end else if (launched && emult) begin
        emult = 1'b0;
      end else if (launched && !if_s.busy) begin
        done = 1;
        break;
      end
      @(negedge clk);
    end
    chk("b2b_timeout", {63'd0, done}, 64'd1);
    chk("b2b_busy_total", 64'(nbusy), 64'd66);
    chk("b2b_hilo_s", {if_s.hi, if_s.lo}, 64'h19);
    chk("b2b_hilo_u", {if_u.hi, if_u.lo}, 64'h19);
  endtask

  // Reset in the middle of a multiplication.
  task automatic reset_mid_run();
    @(negedge clk);
    emult = 1'b1; ea = 32'd9; eb = 32'd7;
    @(posedge clk);
    @(negedge clk);
    emult = 1'b0;
    repeat (9) @(negedge clk);
    chk("pre_rst_busy", {63'd0, if_s.busy}, 64'd1);
    rst = 1'b1;
    emflo = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("rst_busy", {63'd0, if_s.busy}, 64'd0);
    chk("rst_stall", {63'd0, if_s.stall}, 64'd0);
    chk("rst_hilo_s", {if_s.hi, if_s.lo}, 64'd0);
    chk("rst_hilo_u", {if_u.hi, if_u.lo}, 64'd0);
    emflo = 1'b0;
    do_mult(32'd9, 32'd9);
  endtask

  initial begin
    logic [31:0] ra, rb;
    rst = 1'b1;
    emult = 1'b0; emfhi = 1'b0; emflo = 1'b0;
    ea = 32'h0; eb = 32'h0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_hilo_s", {if_s.hi, if_s.lo}, 64'd0);
    chk("reset_hilo_u", {if_u.hi, if_u.lo}, 64'd0);
    chk("reset_busy", {62'd0, if_s.busy, if_u.busy}, 64'd0);
    chk("reset_stall", {62'd0, if_s.stall, if_u.stall}, 64'd0);
    rst = 1'b0;

    do_mult(32'd7, 32'd6);
    do_mult(32'hFFFFFFFD, 32'd5);
    do_mult(32'h80000000, 32'h80000000);
    do_mult(32'hFFFFFFFF, 32'd1);
    do_mult(32'h7FFFFFFF, 32'h80000000);
    for (int i = 0; i < 16; i++) begin
      ra = $urandom;
      rb = $urandom;
      if (i % 4 == 1) ra = 32'h80000000;
      if (i % 5 == 2) rb = 32'hFFFFFFFF;
      do_mult(ra, rb);
    end

    mflo_hazard();
    b2b();
    reset_mid_run();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
